// File: rtl/flag_ctx_pkg.sv
// ============================================================================
// Module : flag_ctx_pkg
// Brief  : Shared flag bit indices, controller state encoding and condition
//          codes for the flag context controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package flag_ctx_pkg;

    localparam int c_FLAG_Z = 3;
    localparam int c_FLAG_C = 2;
    localparam int c_FLAG_N = 1;
    localparam int c_FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP_RD = 2'd1,
        ST_POP_WR = 2'd2
    } state_t;

    localparam logic [3:0] c_CC_EQ = 4'd0;
    localparam logic [3:0] c_CC_NE = 4'd1;
    localparam logic [3:0] c_CC_CS = 4'd2;
    localparam logic [3:0] c_CC_CC = 4'd3;
    localparam logic [3:0] c_CC_MI = 4'd4;
    localparam logic [3:0] c_CC_PL = 4'd5;
    localparam logic [3:0] c_CC_VS = 4'd6;
    localparam logic [3:0] c_CC_VC = 4'd7;
    localparam logic [3:0] c_CC_GE = 4'd8;
    localparam logic [3:0] c_CC_LT = 4'd9;
    localparam logic [3:0] c_CC_GT = 4'd10;
    localparam logic [3:0] c_CC_LE = 4'd11;
    localparam logic [3:0] c_CC_AL = 4'd14;

    function automatic logic cond_eval(input logic [3:0] f, input logic [3:0] cc);
        logic z, c, n, v;
        z = f[c_FLAG_Z];
        c = f[c_FLAG_C];
        n = f[c_FLAG_N];
        v = f[c_FLAG_V];
        case (cc)
            c_CC_EQ: return z;
            c_CC_NE: return !z;
            c_CC_CS: return c;
            c_CC_CC: return !c;
            c_CC_MI: return n;
            c_CC_PL: return !n;
            c_CC_VS: return v;
            c_CC_VC: return !v;
            c_CC_GE: return (n == v);
            c_CC_LT: return (n != v);
            c_CC_GT: return !z && (n == v);
            c_CC_LE: return z || (n != v);
            c_CC_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/flag_context_ctrl_if.sv
// ============================================================================
// Module : flag_context_ctrl_if
// Brief  : Bus bundle between the flag context controller and its neighbours.
//          Optional condition ports appear when FLAG_CTX_COND_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface flag_context_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH) + 1
);
    logic             alu_valid;
    logic             alu_ready;
    logic [3:0]       alu_flags;
    logic             csr_wr;
    logic [3:0]       csr_flags;
    logic             push_req;
    logic             push_ack;
    logic             pop_req;
    logic             pop_done;
    logic [3:0]       cur_flags;
    logic             update_flags;
    logic [3:0]       flags_out;
    logic [PTR_W-1:0] depth;
    logic             stack_full;
    logic             stack_empty;
    logic             ovf_err;
    logic             unf_err;
    logic             err_clr;
`ifdef FLAG_CTX_COND_EN
    logic [3:0]       cond_code;
    logic             cond_true;

    modport master (
        output alu_valid, alu_flags, csr_wr, csr_flags, push_req, pop_req,
               cur_flags, err_clr, cond_code,
        input  alu_ready, push_ack, pop_done, update_flags, flags_out, depth,
               stack_full, stack_empty, ovf_err, unf_err, cond_true
    );
    modport slave (
        input  alu_valid, alu_flags, csr_wr, csr_flags, push_req, pop_req,
               cur_flags, err_clr, cond_code,
        output alu_ready, push_ack, pop_done, update_flags, flags_out, depth,
               stack_full, stack_empty, ovf_err, unf_err, cond_true
    );
`else
    modport master (
        output alu_valid, alu_flags, csr_wr, csr_flags, push_req, pop_req,
               cur_flags, err_clr,
        input  alu_ready, push_ack, pop_done, update_flags, flags_out, depth,
               stack_full, stack_empty, ovf_err, unf_err
    );
    modport slave (
        input  alu_valid, alu_flags, csr_wr, csr_flags, push_req, pop_req,
               cur_flags, err_clr,
        output alu_ready, push_ack, pop_done, update_flags, flags_out, depth,
               stack_full, stack_empty, ovf_err, unf_err
    );
`endif
endinterface

`default_nettype wire

// File: rtl/flag_ctx_stack.sv
// ============================================================================
// Module : flag_ctx_stack
// Brief  : LIFO of saved flag words with occupancy counter and read register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flag_ctx_stack #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [3:0]       i_wr_data,
    output logic      [3:0]       o_rd_data,
    output logic      [PTR_W-1:0] o_depth,
    output logic                  o_full,
    output logic                  o_empty
);
    logic [3:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_depth;
    logic [3:0]       r_rd_data;
    logic [3:0]       w_top;

    assign o_full    = (r_depth == PTR_W'(DEPTH));
    assign o_empty   = (r_depth == '0);
    assign o_depth   = r_depth;
    assign o_rd_data = r_rd_data;

    // Entry at depth-1 is the most recently saved word.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_depth == PTR_W'(i + 1)) w_top = r_mem[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth   <= '0;
            r_rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push && !o_full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_depth == PTR_W'(i)) r_mem[i] <= i_wr_data;
            end
            r_depth <= r_depth + PTR_W'(1);
        end else if (i_pop && !o_empty) begin
            r_rd_data <= w_top;
            r_depth   <= r_depth - PTR_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/flag_context_ctrl.sv
// ============================================================================
// Module : flag_context_ctrl
// Brief  : Selects the status register update source (CSR, ALU, context
//          restore) and saves/restores flags around interrupts.
//          Define FLAG_CTX_COND_EN to add the registered condition evaluator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flag_context_ctrl
    import flag_ctx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    flag_context_ctrl_if.slave bus
);
    state_t           r_state;
    state_t           w_next;
    logic             r_void;
    logic             r_ovf_err;
    logic             r_unf_err;
    logic             w_idle;
    logic             w_push_ack;
    logic             w_pop_accept;
    logic             w_full;
    logic             w_empty;
    logic [3:0]       w_rd_data;
    logic [PTR_W-1:0] w_depth;
    logic             w_update;
    logic [3:0]       w_flags;
    logic             w_alu_ready;
    logic             w_pop_done;

    assign w_idle       = (r_state == ST_IDLE);
    // A simultaneous pop wins; the interrupt sequencer retries the push.
    assign w_push_ack   = bus.push_req && w_idle && !bus.pop_req;
    assign w_pop_accept = bus.pop_req && w_idle;

    flag_ctx_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push_ack),
        .i_pop     (w_pop_accept),
        .i_wr_data (bus.cur_flags),
        .o_rd_data (w_rd_data),
        .o_depth   (w_depth),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_void    <= 1'b0;
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            if (w_pop_accept) r_void <= w_empty;
            r_ovf_err <= (w_push_ack && w_full) || (r_ovf_err && !bus.err_clr);
            r_unf_err <= (w_pop_accept && w_empty) || (r_unf_err && !bus.err_clr);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_update    = 1'b0;
        w_flags     = '0;
        w_alu_ready = 1'b0;
        w_pop_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.csr_wr) begin
                    w_update = 1'b1;
                    w_flags  = bus.csr_flags;
                end else begin
                    w_alu_ready = 1'b1;
                    if (bus.alu_valid) begin
                        w_update = 1'b1;
                        w_flags  = bus.alu_flags;
                    end
                end
                if (bus.pop_req) w_next = ST_POP_RD;
            end
            ST_POP_RD: w_next = ST_POP_WR;
            ST_POP_WR: begin
                w_pop_done = 1'b1;
                if (!r_void) begin
                    w_update = 1'b1;
                    w_flags  = w_rd_data;
                end
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.alu_ready    = w_alu_ready;
    assign bus.push_ack     = w_push_ack;
    assign bus.pop_done     = w_pop_done;
    assign bus.update_flags = w_update;
    assign bus.flags_out    = w_flags;
    assign bus.depth        = w_depth;
    assign bus.stack_full   = w_full;
    assign bus.stack_empty  = w_empty;
    assign bus.ovf_err      = r_ovf_err;
    assign bus.unf_err      = r_unf_err;

`ifdef FLAG_CTX_COND_EN
    logic r_cond_true;

    always_ff @(posedge clk) begin
        if (rst) r_cond_true <= 1'b0;
        else     r_cond_true <= cond_eval(bus.cur_flags, bus.cond_code);
    end

    assign bus.cond_true = r_cond_true;
`endif

endmodule

`default_nettype wire
